// File: rtl/fetch_sequencer_pkg.sv
// Shared constants and encodings for the IF-stage fetch sequencer.
package fetch_sequencer_pkg;

  localparam logic [31:0] RESET_PC        = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DFLT = 32'h0000_4180;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_DRAIN    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    RK_NONE   = 2'd0,
    RK_BRANCH = 2'd1,
    RK_ERET   = 2'd2,
    RK_EXC    = 2'd3
  } redir_kind_e;

endpackage

// File: rtl/fetch_sequencer_redirect_holder.sv
// Holds a redirect that could not be applied yet, plus a deferred exception.
module fetch_sequencer_redirect_holder
  import fetch_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_taken,
  input  logic        exc_defer,
  input  redir_kind_e load_kind,
  input  logic [31:0] load_addr,
  input  logic        consume,
  output logic        pending_valid,
  output logic        pending_exc,
  output logic [31:0] pending_addr
);

  logic        valid_q, valid_d;
  logic        is_eret_q, is_eret_d;
  logic        exc_q, exc_d;
  logic [31:0] addr_q, addr_d;
  logic        load_ok;

  // An eret always wins the slot; a branch may not displace a held eret.
  assign load_ok = (load_kind == RK_ERET) ||
                   ((load_kind == RK_BRANCH) && !(valid_q && is_eret_q));

  always_comb begin
    valid_d   = valid_q;
    is_eret_d = is_eret_q;
    exc_d     = exc_q;
    addr_d    = addr_q;
    if (exc_taken) begin
      valid_d   = 1'b0;
      is_eret_d = 1'b0;
      exc_d     = 1'b0;
      addr_d    = '0;
    end else begin
      if (exc_defer) exc_d = 1'b1;
      if (consume) valid_d = 1'b0;
      if (load_ok) begin
        valid_d   = 1'b1;
        is_eret_d = (load_kind == RK_ERET);
        addr_d    = load_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      is_eret_q <= 1'b0;
      exc_q     <= 1'b0;
      addr_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      is_eret_q <= is_eret_d;
      exc_q     <= exc_d;
      addr_q    <= addr_d;
    end
  end

  assign pending_valid = valid_q;
  assign pending_exc   = exc_q;
  assign pending_addr  = addr_q;

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage control: redirect arbitration, imem handshake sequencing and
// post-exception drain.
//   state    | meaning
//   IDLE     | first cycle after reset release, IF PC holds reset value
//   FETCH    | imem returned last cycle, normal fetch
//   MEM_WAIT | imem has not returned for the current PC yet
//   DRAIN    | flushing wrong-path instructions after an exception
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DFLT,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned CNT_W        = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        imem_ready,
  output logic        imem_req,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  input  logic        id_is_branch,
  input  logic [31:0] id_PC,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] EPC_in,
  output logic        PC_enable,
  output logic        PC_jump_select,
  output logic [31:0] jump_addr,
  output logic        handle_exception,
  output logic        delay_slot,
  output logic [31:0] last_PC,
  output logic        flush,
  output logic        busy
);

  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic             hold_q, hold_d;
  logic [31:0]      last_pc_q, last_pc_d;

  logic        pend_valid, pend_exc;
  logic [31:0] pend_addr;
  logic        exc_taken, exc_defer, consume;
  redir_kind_e load_kind;

  logic        fetch_en, redir_req;
  logic [31:0] redir_addr, live_pc;

  assign fetch_en   = imem_ready & ~stall;
  assign redir_req  = eret_req | branch_valid;
  assign redir_addr = eret_req ? EPC_in : branch_target;
  // While ID was frozen last cycle, keep presenting the PC captured on entry.
  assign live_pc    = hold_q ? last_pc_q : id_PC;

  always_comb begin
    state_d          = state_q;
    drain_cnt_d      = drain_cnt_q;
    imem_req         = 1'b0;
    PC_enable        = 1'b0;
    PC_jump_select   = 1'b0;
    jump_addr        = '0;
    handle_exception = 1'b0;
    flush            = 1'b0;
    exc_taken        = 1'b0;
    exc_defer        = 1'b0;
    consume          = 1'b0;
    load_kind        = RK_NONE;
    case (state_q)
      ST_IDLE: begin
        exc_defer = exc_req;
        state_d   = ST_FETCH;
      end
      ST_FETCH, ST_MEM_WAIT: begin
        imem_req  = 1'b1;
        PC_enable = fetch_en;
        state_d   = imem_ready ? ST_FETCH : ST_MEM_WAIT;
        if (exc_req || pend_exc) begin
          PC_enable        = 1'b1;
          handle_exception = 1'b1;
          flush            = 1'b1;
          jump_addr        = EXC_VECTOR;
          exc_taken        = 1'b1;
          drain_cnt_d      = DRAIN_LOAD;
          state_d          = ST_DRAIN;
        end else if (redir_req) begin
          if (fetch_en) begin
            PC_jump_select = 1'b1;
            jump_addr      = redir_addr;
            consume        = 1'b1;
          end else begin
            load_kind = eret_req ? RK_ERET : RK_BRANCH;
          end
        end else if (pend_valid && fetch_en) begin
          PC_jump_select = 1'b1;
          jump_addr      = pend_addr;
          consume        = 1'b1;
        end
      end
      ST_DRAIN: begin
        imem_req  = 1'b1;
        flush     = 1'b1;
        PC_enable = fetch_en;
        if (exc_req) begin
          PC_enable        = 1'b1;
          handle_exception = 1'b1;
          jump_addr        = EXC_VECTOR;
          exc_taken        = 1'b1;
          drain_cnt_d      = DRAIN_LOAD;
        end else if (fetch_en) begin
          drain_cnt_d = drain_cnt_q - CNT_ONE;
          if (drain_cnt_q == CNT_ONE) state_d = imem_ready ? ST_FETCH : ST_MEM_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign hold_d    = stall;
  assign last_pc_d = live_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= '0;
      hold_q      <= 1'b0;
      last_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      hold_q      <= hold_d;
      last_pc_q   <= last_pc_d;
    end
  end

  fetch_sequencer_redirect_holder u_holder (
    .clk           (clk),
    .reset         (reset),
    .exc_taken     (exc_taken),
    .exc_defer     (exc_defer),
    .load_kind     (load_kind),
    .load_addr     (redir_addr),
    .consume       (consume),
    .pending_valid (pend_valid),
    .pending_exc   (pend_exc),
    .pending_addr  (pend_addr)
  );

  assign delay_slot = (state_q != ST_IDLE) & id_is_branch & ~flush;
  assign last_PC    = (state_q == ST_IDLE) ? '0 : live_pc;
  assign busy       = (state_q != ST_FETCH);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and randomized checks of fetch_sequencer against a cycle model.
module tb_fetch_sequencer;

  localparam logic [31:0] EXC = 32'h0000_4180;
  localparam int          DRAIN = 2;

  logic        clk = 1'b0;
  logic        reset, stall, imem_ready, branch_valid, id_is_branch, exc_req, eret_req;
  logic [31:0] branch_target, id_PC, EPC_in;
  logic        imem_req, PC_enable, PC_jump_select, handle_exception, delay_slot, flush, busy;
  logic [31:0] jump_addr, last_PC;

  int n_total = 0;
  int n_pass  = 0;

  // model state: mode 0 = just out of reset, 1 = fetching, 2 = draining
  int          m_mode, m_drain;
  bit          m_wait, m_pv, m_peret, m_pexc, m_prev_stall;
  logic [31:0] m_paddr, m_prev_val;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .imem_ready(imem_ready), .imem_req(imem_req),
    .branch_valid(branch_valid), .branch_target(branch_target), .id_is_branch(id_is_branch),
    .id_PC(id_PC), .exc_req(exc_req), .eret_req(eret_req), .EPC_in(EPC_in),
    .PC_enable(PC_enable), .PC_jump_select(PC_jump_select), .jump_addr(jump_addr),
    .handle_exception(handle_exception), .delay_slot(delay_slot), .last_PC(last_PC),
    .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_mode = 0; m_drain = 0; m_wait = 0; m_pv = 0; m_peret = 0; m_pexc = 0;
    m_paddr = '0; m_prev_stall = 0; m_prev_val = '0;
  endtask

  task automatic clear_in();
    stall = 0; imem_ready = 1; branch_valid = 0; id_is_branch = 0; exc_req = 0;
    eret_req = 0; branch_target = '0; id_PC = 32'h0000_3000; EPC_in = '0;
  endtask

  // Sample at the falling edge, compare every output, then advance the model.
  task automatic eval();
    logic        e_req, e_pe, e_js, e_he, e_fl, e_ds, e_busy;
    logic [31:0] e_ja, e_lpc, val, tgt;
    int          mode0;
    bit          en;
    @(negedge clk);
    e_req = 0; e_pe = 0; e_js = 0; e_he = 0; e_fl = 0; e_busy = 1; e_ja = '0;
    mode0 = m_mode;
    val = m_prev_stall ? m_prev_val : id_PC;
    en = imem_ready && !stall;
    if (m_mode == 0) begin
      if (exc_req) m_pexc = 1;
      m_mode = 1; m_wait = 0;
    end else if (m_mode == 1) begin
      e_req = 1; e_busy = m_wait; e_pe = en;
      if (exc_req || m_pexc) begin
        e_pe = 1; e_he = 1; e_fl = 1; e_ja = EXC;
        m_pv = 0; m_peret = 0; m_pexc = 0; m_paddr = '0; m_mode = 2; m_drain = DRAIN;
      end else if (eret_req || branch_valid) begin
        tgt = eret_req ? EPC_in : branch_target;
        if (en) begin
          e_js = 1; e_ja = tgt; m_pv = 0;
        end else if (eret_req || !(m_pv && m_peret)) begin
          m_pv = 1; m_peret = eret_req; m_paddr = tgt;
        end
      end else if (m_pv && en) begin
        e_js = 1; e_ja = m_paddr; m_pv = 0;
      end
      m_wait = !imem_ready;
    end else begin
      e_req = 1; e_fl = 1; e_pe = en || exc_req;
      if (exc_req) begin
        e_he = 1; e_ja = EXC; m_drain = DRAIN;
      end else if (en) begin
        m_drain--;
        if (m_drain == 0) begin m_mode = 1; m_wait = !imem_ready; end
      end
    end
    e_ds  = (mode0 != 0) && id_is_branch && !e_fl;
    e_lpc = (mode0 == 0) ? 32'h0 : val;
    m_prev_stall = stall; m_prev_val = val;
    chk("imem_req", imem_req, e_req);
    chk("PC_enable", PC_enable, e_pe);
    chk("PC_jump_select", PC_jump_select, e_js);
    chk("jump_addr", jump_addr, e_ja);
    chk("handle_exception", handle_exception, e_he);
    chk("flush", flush, e_fl);
    chk("delay_slot", delay_slot, e_ds);
    chk("last_PC", last_PC, e_lpc);
    chk("busy", busy, e_busy);
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic step();
    eval(); adv();
  endtask

  initial begin
    clear_in();
    id_is_branch = 1; id_PC = 32'h0000_1234;
    reset = 0;
    model_reset();
    #12;
    chk("rst_PC_enable", PC_enable, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_busy", busy, 1);
    chk("rst_delay_slot", delay_slot, 0);
    chk("rst_last_PC", last_PC, 0);
    adv();
    reset = 1; id_is_branch = 0;
    eval(); chk("idle_PC_enable", PC_enable, 0); adv();
    for (int i = 0; i < 3; i++) begin
      eval(); chk("seq_PC_enable", PC_enable, 1); chk("seq_jump_sel", PC_jump_select, 0); adv();
    end

    // taken branch applied in the same cycle
    id_PC = 32'h0000_3010; id_is_branch = 1; branch_valid = 1; branch_target = 32'h0000_3040;
    eval();
    chk("br_jump_sel", PC_jump_select, 1); chk("br_jump_addr", jump_addr, 32'h0000_3040);
    chk("br_delay_slot", delay_slot, 1); chk("br_last_PC", last_PC, 32'h0000_3010);
    adv();

    // branch held while imem is not ready
    imem_ready = 0; branch_target = 32'h0000_3080; id_PC = 32'h0000_3014;
    for (int i = 0; i < 3; i++) begin
      eval(); chk("wait_PC_enable", PC_enable, 0); chk("wait_jump_sel", PC_jump_select, 0); adv();
    end
    imem_ready = 1; branch_valid = 0; id_is_branch = 0;
    eval(); chk("pend_jump_sel", PC_jump_select, 1); chk("pend_jump_addr", jump_addr, 32'h0000_3080); adv();
    eval(); chk("pend_cleared", PC_jump_select, 0); adv();

    // exception under stall discards a held branch, then drains
    stall = 1; branch_valid = 1; branch_target = 32'h0000_3200;
    step();
    branch_valid = 0; exc_req = 1;
    eval(); chk("exc_he", handle_exception, 1); chk("exc_pe", PC_enable, 1); chk("exc_flush", flush, 1); adv();
    exc_req = 0; stall = 0; branch_valid = 1; branch_target = 32'h0000_3300; id_is_branch = 1;
    for (int i = 0; i < 2; i++) begin
      eval(); chk("drain_flush", flush, 1); chk("drain_jump_sel", PC_jump_select, 0);
      chk("drain_ds", delay_slot, 0); adv();
    end
    branch_valid = 0; id_is_branch = 0;
    eval(); chk("post_drain_flush", flush, 0); chk("post_drain_busy", busy, 0);
    chk("post_drain_no_pend", PC_jump_select, 0); adv();

    // eret beats branch; exception beats both
    eret_req = 1; EPC_in = 32'h0000_3024; branch_valid = 1; branch_target = 32'h0000_3100;
    eval(); chk("eret_jump_addr", jump_addr, 32'h0000_3024); chk("eret_jump_sel", PC_jump_select, 1); adv();
    exc_req = 1;
    eval(); chk("exc_eret_he", handle_exception, 1); chk("exc_eret_no_jump", PC_jump_select, 0); adv();
    clear_in();
    step(); step();

    // asynchronous reset in the middle of a drain
    exc_req = 1; step(); exc_req = 0; id_is_branch = 1;
    #2 reset = 0;
    #1;
    chk("arst_flush", flush, 0); chk("arst_PC_enable", PC_enable, 0);
    chk("arst_imem_req", imem_req, 0); chk("arst_busy", busy, 1); chk("arst_ds", delay_slot, 0);
    model_reset();
    adv();
    reset = 1; id_is_branch = 0;
    eval(); chk("arst_idle", PC_enable, 0); adv();
    eval(); chk("arst_no_pend", PC_jump_select, 0); chk("arst_fetch_busy", busy, 0); adv();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      stall         = ($urandom_range(0, 3) == 0);
      imem_ready    = ($urandom_range(0, 3) != 0);
      branch_valid  = ($urandom_range(0, 4) == 0);
      eret_req      = ($urandom_range(0, 9) == 0);
      exc_req       = ($urandom_range(0, 19) == 0);
      id_is_branch  = branch_valid | ($urandom_range(0, 3) == 0);
      branch_target = $urandom & 32'hFFFF_FFFC;
      EPC_in        = $urandom & 32'hFFFF_FFFC;
      id_PC         = $urandom & 32'hFFFF_FFFC;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
